// File: rtl/biriscv_ifetch_pkg.sv
// Shared definitions for the instruction-fetch bridge: FSM state encoding,
// fetch alignment and the width of the per-request tag.
package biriscv_ifetch_pkg;

    // Memory reads are 64 bits wide, so fetch addresses are 8-byte aligned
    localparam int FETCH_ALIGN_W = 3;

    // One bit per outstanding request: 1 = answered locally (range error)
    localparam int TAG_W = 1;

    typedef enum logic [1:0] {
        STATE_RUN   = 2'd0,
        STATE_DRAIN = 2'd1,
        STATE_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/biriscv_ifetch_bridge_if.sv
// Fetch-side (icache replacement) and memory-side signals of the bridge.
// slave: the bridge's view. master: the frontend/memory environment's view.
interface biriscv_ifetch_bridge_if;
    logic        icache_rd_i;
    logic [31:0] icache_pc_i;
    logic [1:0]  icache_priv_i;
    logic        icache_flush_i;
    logic        icache_invalidate_i;
    logic        icache_accept_o;
    logic        icache_valid_o;
    logic [63:0] icache_inst_o;
    logic        icache_error_o;
    logic        icache_page_fault_o;
    logic        mem_rd_o;
    logic [31:0] mem_addr_o;
    logic        mem_accept_i;
    logic        mem_valid_i;
    logic [63:0] mem_data_i;
    logic        mem_error_i;
    logic        mem_flush_o;

    modport slave (
        input  icache_rd_i, icache_pc_i, icache_priv_i, icache_flush_i, icache_invalidate_i,
        output icache_accept_o, icache_valid_o, icache_inst_o, icache_error_o, icache_page_fault_o,
        output mem_rd_o, mem_addr_o, mem_flush_o,
        input  mem_accept_i, mem_valid_i, mem_data_i, mem_error_i
    );

    modport master (
        output icache_rd_i, icache_pc_i, icache_priv_i, icache_flush_i, icache_invalidate_i,
        input  icache_accept_o, icache_valid_o, icache_inst_o, icache_error_o, icache_page_fault_o,
        input  mem_rd_o, mem_addr_o, mem_flush_o,
        output mem_accept_i, mem_valid_i, mem_data_i, mem_error_i
    );
endinterface

// File: rtl/biriscv_ifetch_tagq.sv
// In-order tag FIFO for outstanding fetches. One entry per accepted request,
// popped when its response retires. count doubles as the outstanding counter.
module biriscv_ifetch_tagq
    import biriscv_ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] head,
    output logic [TAG_W-1:0] tail,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [TAG_W-1:0] entry_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, tail_ptr;

    // Depth need not be a power of two, so wrap explicitly
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign tail_ptr = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - PTR_W'(1);
    assign head     = entry_q[rd_ptr_q];
    assign tail     = entry_q[tail_ptr];

    // Storage, pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
        end else begin
            if (push) begin
                entry_q[wr_ptr_q] <= push_tag;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/biriscv_ifetch_bridge.sv
// Fetch bridge: turns frontend fetch requests into 64-bit uncached reads with
// in-order responses, a bounded outstanding count, and drain-then-flush.
// Optional: define BIRISCV_IFETCH_RANGE_CHECK_EN to answer fetches outside
// [EXEC_BASE, EXEC_BASE+EXEC_SIZE) locally with error=1 and no memory read.
module biriscv_ifetch_bridge
    import biriscv_ifetch_pkg::*;
#(
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          OUTSTANDING_W   = 2,
    parameter logic [31:0] EXEC_BASE       = 32'h0000_0000,
    parameter logic [31:0] EXEC_SIZE       = 32'h8000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    biriscv_ifetch_bridge_if.slave bus
);
    localparam logic [OUTSTANDING_W-1:0] MAX_CNT = OUTSTANDING_W'(MAX_OUTSTANDING);
    localparam logic [OUTSTANDING_W-1:0] CNT_ONE = OUTSTANDING_W'(1);

    state_e                   state_q, state_d;
    logic                     flush_in, local_err, can_issue, accept, retire;
    logic                     head_local, tail_local, drain_done;
    logic [TAG_W-1:0]         head_tag, tail_tag;
    logic [OUTSTANDING_W-1:0] count;
    logic                     resp_valid_q, resp_err_q;
    logic [63:0]              resp_inst_q;
    logic                     unused_in;

    assign unused_in = ^{bus.icache_priv_i, bus.icache_pc_i[FETCH_ALIGN_W-1:0]};
    assign flush_in  = bus.icache_flush_i | bus.icache_invalidate_i;

    biriscv_ifetch_tagq #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (OUTSTANDING_W)
    ) u_tagq (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (accept),
        .push_tag (TAG_W'(local_err)),
        .pop      (retire),
        .head     (head_tag),
        .tail     (tail_tag),
        .count    (count)
    );

`ifdef BIRISCV_IFETCH_RANGE_CHECK_EN
    logic [32:0] win_end, pc_ext;
    assign pc_ext     = {1'b0, bus.icache_pc_i};
    assign win_end    = {1'b0, EXEC_BASE} + {1'b0, EXEC_SIZE};
    assign local_err  = ~((pc_ext >= {1'b0, EXEC_BASE}) & (pc_ext < win_end));
    assign head_local = (count != '0) & head_tag[0];
    assign tail_local = (count != '0) & tail_tag[0];
`else
    // Every fetch goes to memory; tags are constant 0 so only the count matters
    logic unused_cfg;
    assign unused_cfg = ^{head_tag, tail_tag, EXEC_BASE, EXEC_SIZE};
    assign local_err  = 1'b0;
    assign head_local = 1'b0;
    assign tail_local = 1'b0;
`endif

    // Never issue behind a local entry: memory cannot be stalled while it sits at the head
    assign can_issue = rst_ni & (state_q == STATE_RUN) & ~flush_in
                     & (count < MAX_CNT) & ~tail_local;
    assign accept    = bus.icache_rd_i & can_issue & (local_err | bus.mem_accept_i);
    assign retire    = (count != '0) & (head_local | bus.mem_valid_i);

    // In DRAIN nothing is accepted, so the post-retire count is count - retire
    assign drain_done = (count == '0) | ((count == CNT_ONE) & retire);

    assign bus.mem_rd_o            = bus.icache_rd_i & can_issue & ~local_err;
    assign bus.mem_addr_o          = {bus.icache_pc_i[31:FETCH_ALIGN_W], {FETCH_ALIGN_W{1'b0}}};
    assign bus.mem_flush_o         = (state_q == STATE_FLUSH);
    assign bus.icache_accept_o     = accept;
    assign bus.icache_valid_o      = resp_valid_q;
    assign bus.icache_inst_o       = resp_inst_q;
    assign bus.icache_error_o      = resp_err_q;
    assign bus.icache_page_fault_o = 1'b0;

    // Register the retiring response so it appears for exactly one cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_q <= 1'b0;
            resp_inst_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= retire;
            if (retire) begin
                resp_inst_q <= head_local ? 64'd0 : bus.mem_data_i;
                resp_err_q  <= head_local | bus.mem_error_i;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= STATE_RUN;
        else         state_q <= state_d;
    end

    // Next state: flush drains outstanding work, then pulses downstream once
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            STATE_RUN:   if (flush_in) state_d = STATE_DRAIN;
            STATE_DRAIN: if (drain_done) state_d = STATE_FLUSH;
            STATE_FLUSH: state_d = STATE_RUN;
            default:     state_d = STATE_RUN;
        endcase
    end
endmodule

// File: tb/tb_biriscv_ifetch_bridge.sv
// Directed scenarios followed by a randomized phase against a queue-based
// memory/scoreboard model of the fetch bridge.
module tb_biriscv_ifetch_bridge;
    localparam int MAXO = 2;
`ifdef BIRISCV_IFETCH_RANGE_CHECK_EN
    localparam logic [31:0] TB_EXEC_SIZE = 32'h0000_1000;
`else
    localparam logic [31:0] TB_EXEC_SIZE = 32'h8000_0000;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    biriscv_ifetch_bridge_if bus();

    biriscv_ifetch_bridge #(
        .MAX_OUTSTANDING (MAXO),
        .OUTSTANDING_W   (2),
        .EXEC_BASE       (32'h0000_0000),
        .EXEC_SIZE       (TB_EXEC_SIZE)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_resp(input logic [63:0] d, input logic e);
        bus.mem_valid_i = 1'b1;
        bus.mem_data_i  = d;
        bus.mem_error_i = e;
    endtask

    task automatic mem_off();
        bus.mem_valid_i = 1'b0;
        bus.mem_data_i  = '0;
        bus.mem_error_i = 1'b0;
    endtask

    task automatic chk_resp(input string tag, input logic [63:0] d, input logic e);
        chk({tag, "_vld"}, bus.icache_valid_o, 1'b1);
        chk({tag, "_inst"}, bus.icache_inst_o, d);
        chk({tag, "_err"}, bus.icache_error_o, e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_acc"}, bus.icache_accept_o, 1'b0);
        chk({tag, "_vld"}, bus.icache_valid_o, 1'b0);
        chk({tag, "_inst"}, bus.icache_inst_o, 64'd0);
        chk({tag, "_err"}, bus.icache_error_o, 1'b0);
        chk({tag, "_pf"}, bus.icache_page_fault_o, 1'b0);
        chk({tag, "_mrd"}, bus.mem_rd_o, 1'b0);
        chk({tag, "_addr"}, bus.mem_addr_o, 32'd0);
        chk({tag, "_mfl"}, bus.mem_flush_o, 1'b0);
    endtask

    // Randomized-phase model: requests the memory has accepted but not answered
    logic [63:0] mq_data[$];
    logic        mq_err[$];

    initial begin
        logic        exp_acc, exp_rd, pv, pe;
        logic [63:0] pd;
        bus.icache_rd_i = 0; bus.icache_pc_i = '0; bus.icache_priv_i = 2'd3;
        bus.icache_flush_i = 0; bus.icache_invalidate_i = 0;
        bus.mem_accept_i = 0;
        mem_off();

        // Reset state
        #2;
        chk_all_zero("rst");
        cyc(); cyc();
        rst_n = 1'b1;

        // Single fetch
        cyc(); bus.icache_rd_i = 1; bus.icache_pc_i = 32'h104; bus.mem_accept_i = 1; #1;
        chk("s_mrd", bus.mem_rd_o, 1'b1);
        chk("s_addr", bus.mem_addr_o, 32'h100);
        chk("s_acc", bus.icache_accept_o, 1'b1);
        cyc(); bus.icache_rd_i = 0; #1;
        chk("s_vld0", bus.icache_valid_o, 1'b0);
        cyc(); mem_resp(64'hDEADBEEF_00000013, 1'b0); #1;
        chk("s_vld1", bus.icache_valid_o, 1'b0);
        cyc(); mem_off(); #1;
        chk_resp("s_rsp", 64'hDEADBEEF_00000013, 1'b0);
        cyc(); #1;
        chk("s_vld2", bus.icache_valid_o, 1'b0);

        // Outstanding limit
        cyc(); bus.icache_rd_i = 1; bus.icache_pc_i = 32'h200; #1;
        chk("o_acc0", bus.icache_accept_o, 1'b1);
        cyc(); bus.icache_pc_i = 32'h208; #1;
        chk("o_acc1", bus.icache_accept_o, 1'b1);
        cyc(); bus.icache_pc_i = 32'h210; #1;
        chk("o_acc2", bus.icache_accept_o, 1'b0);
        chk("o_mrd2", bus.mem_rd_o, 1'b0);
        cyc(); mem_resp(64'h1111, 1'b0); #1;
        chk("o_acc3", bus.icache_accept_o, 1'b0);
        cyc(); mem_off(); #1;
        chk("o_acc4", bus.icache_accept_o, 1'b1);
        chk_resp("o_r1", 64'h1111, 1'b0);
        cyc(); bus.icache_rd_i = 0; mem_resp(64'h2222, 1'b1); #1;
        cyc(); mem_resp(64'h3333, 1'b0); #1;
        chk_resp("o_r2", 64'h2222, 1'b1);
        cyc(); mem_off(); #1;
        chk_resp("o_r3", 64'h3333, 1'b0);

        // Flush while busy (second pulse during DRAIN is absorbed)
        cyc(); bus.icache_rd_i = 1; bus.icache_pc_i = 32'h300; #1;
        chk("f_acc0", bus.icache_accept_o, 1'b1);
        cyc(); bus.icache_pc_i = 32'h308; #1;
        chk("f_acc1", bus.icache_accept_o, 1'b1);
        cyc(); bus.icache_flush_i = 1; #1;
        chk("f_acc2", bus.icache_accept_o, 1'b0);
        cyc(); bus.icache_flush_i = 0; #1;
        chk("f_acc3", bus.icache_accept_o, 1'b0);
        chk("f_mfl3", bus.mem_flush_o, 1'b0);
        cyc(); mem_resp(64'h4444, 1'b0); bus.icache_invalidate_i = 1; #1;
        chk("f_acc4", bus.icache_accept_o, 1'b0);
        chk("f_mfl4", bus.mem_flush_o, 1'b0);
        cyc(); mem_off(); bus.icache_invalidate_i = 0; #1;
        chk_resp("f_r1", 64'h4444, 1'b0);
        chk("f_acc5", bus.icache_accept_o, 1'b0);
        cyc(); mem_resp(64'h5555, 1'b0); #1;
        chk("f_acc6", bus.icache_accept_o, 1'b0);
        chk("f_mfl6", bus.mem_flush_o, 1'b0);
        cyc(); mem_off(); #1;
        chk_resp("f_r2", 64'h5555, 1'b0);
        chk("f_acc7", bus.icache_accept_o, 1'b0);
        chk("f_mfl7", bus.mem_flush_o, 1'b1);
        cyc(); #1;
        chk("f_acc8", bus.icache_accept_o, 1'b1);
        chk("f_mfl8", bus.mem_flush_o, 1'b0);
        cyc(); bus.icache_rd_i = 0; mem_resp(64'h6666, 1'b0); #1;
        chk("f_mfl9", bus.mem_flush_o, 1'b0);
        cyc(); mem_off(); #1;
        chk_resp("f_r3", 64'h6666, 1'b0);

        // Flush/request collision
        cyc(); bus.icache_rd_i = 1; bus.icache_pc_i = 32'h400; bus.icache_flush_i = 1; #1;
        chk("c_mrd0", bus.mem_rd_o, 1'b0);
        chk("c_acc0", bus.icache_accept_o, 1'b0);
        cyc(); bus.icache_flush_i = 0; #1;
        chk("c_acc1", bus.icache_accept_o, 1'b0);
        chk("c_mfl1", bus.mem_flush_o, 1'b0);
        cyc(); #1;
        chk("c_acc2", bus.icache_accept_o, 1'b0);
        chk("c_mfl2", bus.mem_flush_o, 1'b1);
        cyc(); #1;
        chk("c_acc3", bus.icache_accept_o, 1'b1);
        chk("c_mrd3", bus.mem_rd_o, 1'b1);
        chk("c_mfl3", bus.mem_flush_o, 1'b0);
        cyc(); bus.icache_rd_i = 0; mem_resp(64'h7777, 1'b0); #1;
        cyc(); mem_off(); #1;
        chk_resp("c_r", 64'h7777, 1'b0);

`ifdef BIRISCV_IFETCH_RANGE_CHECK_EN
        // Out-of-window fetch answered locally; next request waits behind it
        cyc(); bus.icache_rd_i = 1; bus.icache_pc_i = 32'h2000; #1;
        chk("g_mrd0", bus.mem_rd_o, 1'b0);
        chk("g_acc0", bus.icache_accept_o, 1'b1);
        cyc(); bus.icache_pc_i = 32'h100; #1;
        chk("g_acc1", bus.icache_accept_o, 1'b0);
        chk("g_mrd1", bus.mem_rd_o, 1'b0);
        cyc(); #1;
        chk_resp("g_r0", 64'd0, 1'b1);
        chk("g_acc2", bus.icache_accept_o, 1'b1);
        cyc(); bus.icache_rd_i = 0; mem_resp(64'h8888, 1'b0); #1;
        cyc(); mem_off(); #1;
        chk_resp("g_r1", 64'h8888, 1'b0);
`endif

        // Reset mid-operation
        cyc(); bus.icache_rd_i = 1; bus.icache_pc_i = 32'h500; #1;
        chk("x_acc0", bus.icache_accept_o, 1'b1);
        cyc(); bus.icache_pc_i = 32'h508; #1;
        chk("x_acc1", bus.icache_accept_o, 1'b1);
        cyc(); bus.icache_pc_i = 32'h0; rst_n = 1'b0; #1;
        chk_all_zero("x_rst");
        cyc(); rst_n = 1'b1; bus.icache_rd_i = 0; #1;
        cyc(); mem_resp(64'hBAD0_BAD0, 1'b1); #1;
        cyc(); mem_off(); #1;
        chk("x_stray", bus.icache_valid_o, 1'b0);
        cyc(); bus.icache_rd_i = 1; bus.icache_pc_i = 32'h60C; #1;
        chk("x_acc2", bus.icache_accept_o, 1'b1);
        chk("x_addr", bus.mem_addr_o, 32'h608);
        cyc(); bus.icache_rd_i = 0; mem_resp(64'h9999, 1'b0); #1;
        cyc(); mem_off(); #1;
        chk_resp("x_r", 64'h9999, 1'b0);
        cyc(); #1;

        // Randomized traffic: memory answers accepted reads in order after random delays
        pv = 1'b0; pd = '0; pe = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cyc();
            bus.icache_rd_i  = ($urandom_range(0, 3) != 0);
`ifdef BIRISCV_IFETCH_RANGE_CHECK_EN
            bus.icache_pc_i  = $urandom_range(0, 32'hFFF) & 32'hFFFF_FFFC;
`else
            bus.icache_pc_i  = $urandom & 32'hFFFF_FFFC;
`endif
            bus.mem_accept_i = ($urandom_range(0, 9) < 7);
            if (mq_data.size() != 0 && $urandom_range(0, 9) < 4) mem_resp(mq_data[0], mq_err[0]);
            else begin
                mem_off();
                bus.mem_data_i = {$urandom, $urandom};
            end
            #1;
            exp_rd  = bus.icache_rd_i && (mq_data.size() < MAXO);
            exp_acc = exp_rd && bus.mem_accept_i;
            chk("r_mrd", bus.mem_rd_o, exp_rd);
            chk("r_acc", bus.icache_accept_o, exp_acc);
            if (exp_rd) chk("r_addr", bus.mem_addr_o, {bus.icache_pc_i[31:3], 3'b000});
            chk("r_vld", bus.icache_valid_o, pv);
            if (pv) begin
                chk("r_inst", bus.icache_inst_o, pd);
                chk("r_err", bus.icache_error_o, pe);
            end
            pv = bus.mem_valid_i;
            if (bus.mem_valid_i) begin
                pd = mq_data.pop_front();
                pe = mq_err.pop_front();
            end
            if (exp_acc) begin
                mq_data.push_back({$urandom, $urandom});
                mq_err.push_back($urandom_range(0, 9) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
